// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between the fetch and data ports.
// Round-robin grant, holds the access until mem_ready or timeout, then a one-cycle ack.
module mem_port_arbiter #(
    parameter int unsigned n       = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         if_req,
    input  logic [n-1:0] if_addr,
    output logic         if_ack,
    input  logic         dm_req,
    input  logic         dm_we,
    input  logic [n-1:0] dm_addr,
    input  logic [n-1:0] dm_wdata,
    output logic         dm_ack,
    output logic [n-1:0] rdata,
    output logic         err,
    output logic         mem_sel,
    output logic         mem_en,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic [n-1:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

    state_t         state_q;
    logic           owner_q;
    logic           last_owner_q;
    logic           err_q;
    logic [CW-1:0]  cnt_q;
    logic [n-1:0]   rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (if_req || dm_req) begin
                        // Both pending: alternate away from the previous owner.
                        owner_q <= (if_req && dm_req) ? ~last_owner_q : dm_req;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mem_ready) begin
                        rdata_q <= mem_rdata;
                        err_q   <= 1'b0;
                        state_q <= StResp;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    last_owner_q <= owner_q;
                    cnt_q        <= '0;
                    err_q        <= 1'b0;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        mem_en    = (state_q == StAccess);
        mem_sel   = owner_q;
        mem_we    = mem_en & owner_q & dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_en) begin
            mem_addr  = owner_q ? dm_addr : if_addr;
            mem_wdata = owner_q ? dm_wdata : '0;
        end
        if_ack = (state_q == StResp) & ~owner_q;
        dm_ack = (state_q == StResp) & owner_q;
        rdata  = rdata_q;
        err    = err_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected acks,
// a negedge monitor pops and compares them as acks appear.
module tb_mem_port_arbiter;

    localparam logic [31:0] K = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_ack;
    logic [31:0] rdata;
    logic        err;
    logic        mem_sel;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   wait_cfg = 0;
    int   en_cnt = 0;
    logic ready_force = 1'b0;

    mem_port_arbiter #(.n(32), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .rdata     (rdata),
        .err       (err),
        .mem_sel   (mem_sel),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        acc_cnt <= mem_en ? acc_cnt + 1 : 0;
    end

    // Memory model: data is a function of address; ready after wait_cfg access cycles.
    assign mem_rdata = mem_addr ^ K;
    assign mem_ready = ready_force | (mem_en & (acc_cnt >= wait_cfg));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ack(input logic port, input logic [31:0] data, input logic e,
                              input int lat);
        exp_t x;
        x.port = port;
        x.data = data;
        x.err  = e;
        x.cyc  = cyc + lat;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (if_ack || dm_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: got if_ack=%0b dm_ack=%0b at cycle %0d, required none",
                         if_ack, dm_ack, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("ack_dm", 32'(dm_ack), 32'(e.port));
                chk("ack_if", 32'(if_ack), 32'(!e.port));
                chk("ack_rdata", rdata, e.data);
                chk("ack_err", 32'(err), 32'(e.err));
                chk("ack_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_ctrl", 32'({if_ack, dm_ack, err, mem_en, mem_we, mem_sel}), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single fetch, immediate ready
        wait_cfg = 0;
        if_req = 1'b1; if_addr = 32'h100;
        expect_ack(1'b0, 32'h100 ^ K, 1'b0, 2);
        @(posedge clk); @(negedge clk);
        chk("f_en", 32'(mem_en), 32'd1);
        chk("f_sel", 32'(mem_sel), 32'd0);
        chk("f_addr", mem_addr, 32'h100);
        chk("f_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1 if_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Store with 3 wait cycles
        wait_cfg = 3;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF;
        expect_ack(1'b1, 32'h2000 ^ K, 1'b0, 5);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            chk("st_we", 32'(mem_we), 32'd1);
            chk("st_sel", 32'(mem_sel), 32'd1);
        end
        chk("st_wdata", mem_wdata, 32'hDEADBEEF);
        chk("st_addr", mem_addr, 32'h2000);
        @(posedge clk); #1 dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        chk("st_en_off", 32'({mem_en, mem_we}), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Both held: fetch, data, fetch, data every 3 cycles
        wait_cfg = 0;
        if_req = 1'b1; if_addr = 32'h300;
        dm_req = 1'b1; dm_addr = 32'h400;
        expect_ack(1'b0, 32'h300 ^ K, 1'b0, 2);
        expect_ack(1'b1, 32'h400 ^ K, 1'b0, 5);
        expect_ack(1'b0, 32'h300 ^ K, 1'b0, 8);
        expect_ack(1'b1, 32'h400 ^ K, 1'b0, 11);
        repeat (12) @(posedge clk);
        #1 if_req = 1'b0; dm_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Timeout: memory never ready
        wait_cfg = 1000;
        if_req = 1'b1; if_addr = 32'h500;
        expect_ack(1'b0, 32'd0, 1'b1, 17);
        en_cnt = 0;
        repeat (17) begin
            @(posedge clk); @(negedge clk);
            en_cnt += int'(mem_en);
        end
        @(posedge clk); #1 if_req = 1'b0;
        chk("to_en_cycles", en_cnt, 32'd16);
        @(negedge clk);
        chk("to_err_clear", 32'(err), 32'd0);
        @(posedge clk); #1;
        wait_cfg = 0;
        if_req = 1'b1; if_addr = 32'h600;
        expect_ack(1'b0, 32'h600 ^ K, 1'b0, 2);
        repeat (2) @(posedge clk);
        #1 if_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in second access cycle of a store
        wait_cfg = 1000;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h700; dm_wdata = 32'h1234;
        @(posedge clk); @(negedge clk);
        chk("ra_we", 32'(mem_we), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h800;
        wait_cfg = 0;
        #1;
        chk("ra_ctrl", 32'({if_ack, dm_ack, err, mem_en, mem_we, mem_sel}), 32'd0);
        chk("ra_addr", mem_addr, 32'd0);
        chk("ra_wdata", mem_wdata, 32'd0);
        chk("ra_rdata", rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        expect_ack(1'b0, 32'h800 ^ K, 1'b0, 2);
        expect_ack(1'b1, 32'h700 ^ K, 1'b0, 5);
        @(posedge clk); @(negedge clk);
        chk("ra_first_sel", 32'(mem_sel), 32'd0);
        chk("ra_first_addr", mem_addr, 32'h800);
        repeat (5) @(posedge clk);
        #1 if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // mem_ready in IDLE is ignored
        ready_force = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("idle_rdy_en", 32'(mem_en), 32'd0);
        chk("idle_rdy_rdata", rdata, 32'h700 ^ K);
        @(posedge clk); #1 ready_force = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_rdy_rdata2", rdata, 32'h700 ^ K);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-ported unified instruction/data memory of the RISC-V core.
- Grants the memory to either the fetch port or the data (load/store) port, and drives the select of the shared address/data steering mux.
- Holds the selected access until the memory signals ready, then returns a one-cycle acknowledge with read data to the owner.
- Includes a timeout watchdog so a non-responding memory cannot hang the pipeline.

Parameters:
- n, 32, address and data width in bits.
- TIMEOUT, 16, maximum ACCESS cycles before a forced error completion (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_req  input  1  fetch request; held high and stable until if_ack.
- if_addr  input  n  fetch address.
- if_ack  output  1  one-cycle fetch completion pulse.
- dm_req  input  1  data request; held high and stable until dm_ack.
- dm_we  input  1  data write enable (1 = store).
- dm_addr  input  n  data address.
- dm_wdata  input  n  store data.
- dm_ack  output  1  one-cycle data completion pulse.
- rdata  output  n  registered read data, valid while if_ack or dm_ack is high.
- err  output  1  high with the ack when the access timed out.
- mem_sel  output  1  steering mux select: 0 = fetch, 1 = data.
- mem_en  output  1  memory access enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  n  steered address.
- mem_wdata  output  n  steered write data.
- mem_rdata  input  n  memory read data.
- mem_ready  input  1  memory completion, sampled only in ACCESS.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State = IDLE; owner = 0; last_owner = 1 (data).
  - Timeout counter = 0; rdata = 0.
  - All outputs = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request pending: stay in IDLE.
  - Exactly one request pending: register that port as owner, go to ACCESS.
  - Both pending: owner = ~last_owner (two-way round robin), go to ACCESS.
- ACCESS:
  - mem_en = 1; mem_sel = owner.
  - mem_addr = owner ? dm_addr : if_addr.
  - mem_we = owner & dm_we.
  - mem_wdata = owner ? dm_wdata : 0.
  - Counter increments each cycle.
  - If mem_ready = 1: capture rdata ← mem_rdata, err ← 0, go to RESP.
  - Else if counter = TIMEOUT−1: capture rdata ← 0, err ← 1, go to RESP.
  - mem_ready takes priority over timeout in the same cycle.
- RESP (exactly one cycle):
  - Owner's ack = 1; mem_en = mem_we = 0.
  - last_owner ← owner; counter ← 0; go to IDLE.
  - err is cleared on leaving RESP.
- Outside ACCESS: mem_en, mem_we, mem_addr, mem_wdata = 0; mem_sel holds the last owner.
- Requests are never re-sampled in RESP. A requester therefore drops req in its ack cycle and cannot be double-granted.
- Latency: req high in IDLE at cycle t gives mem_en at t+1. With mem_ready at t+1, the ack is at t+2. Every extra memory wait cycle adds one cycle.
- Back-to-back: after RESP, IDLE re-arbitrates. Minimum issue interval per access is 3 cycles.
- A req deasserted mid-ACCESS is a protocol violation; the access still completes and the ack is still issued.
- mem_ready outside ACCESS is ignored.
- Reset asserted mid-ACCESS or in RESP aborts immediately: no ack is produced and outputs return to reset values.

Test Plan:
- Reset, then if_req = 1 with if_addr = 0x100 and mem_ready tied 1 → mem_en, mem_sel = 0, mem_addr = 0x100 at t+1; if_ack = 1 with rdata = mem_rdata at t+2; err = 0.
- dm_req = 1, dm_we = 1, dm_addr = 0x2000, dm_wdata = 0xDEADBEEF, mem_ready after 3 wait cycles → mem_we = 1, mem_sel = 1 for 4 cycles; single dm_ack pulse; if_ack never asserted.
- if_req and dm_req both held continuously after reset, ready immediate → grants alternate fetch, data, fetch, data; each ack spaced 3 cycles.
- mem_ready held 0 with TIMEOUT = 16 → mem_en high exactly 16 cycles; then ack with err = 1 and rdata = 0; next request completes normally with err = 0.
- rst_n pulled low in the second ACCESS cycle of a store → all outputs 0 immediately, no ack; after release, a pending if_req is granted first (last_owner = data).
- mem_ready pulsed while in IDLE with no request → no state change, no ack, rdata unchanged.
